// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch/issue stage and its neighbours.
// Contents: opcode constants, fetch FSM state type, default reset PC.
package mips_pkg;

  localparam int          WIDTH_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_ISSUE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch unit.
// Ports:
//   pc_plus4_i  - address of the instruction after the current one
//   imm_i       - 16-bit branch offset (in words, sign-extended)
//   jaddr_i     - 26-bit jump target field
//   jump_i      - jump request, highest priority
//   branch_i    - branch instruction indicator
//   zero_i      - ULA zero flag (branch condition)
//   next_pc_o   - selected next PC
module next_pc_calc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_plus4_i,
  input  logic [15:0]      imm_i,
  input  logic [25:0]      jaddr_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             zero_i,
  output logic [WIDTH-1:0] next_pc_o
);

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;

  // Word offset -> byte offset; the add wraps modulo 2^WIDTH.
  assign br_off    = {{(WIDTH-18){imm_i[15]}}, imm_i, 2'b00};
  assign br_target = pc_plus4_i + br_off;
  // Jump stays within the 256 MB region of the delay-free successor.
  assign j_target  = {pc_plus4_i[WIDTH-1:28], jaddr_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i) begin
      next_pc_o = j_target;
    end else if (branch_i && zero_i) begin
      next_pc_o = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch/issue stage: owns the PC and instruction
// register, presents decode fields and selects the next PC after execution.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata  - instruction memory read handshake
//   instr_valid                - IR holds an instruction awaiting execution
//   OP, Funct, rs, rt, rd,
//   imm, jaddr                 - fields sliced straight from IR
//   pc, pc_plus4               - address of the IR instruction and its successor
//   exec_done, Jump, Branch,
//   Zero                       - completion and control-flow inputs from datapath
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int          WIDTH    = WIDTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [5:0]       OP,
  output logic [5:0]       Funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic [25:0]      jaddr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  input  logic             exec_done,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             Zero
);

  localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [WIDTH-1:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= {RESET_PC_W[WIDTH-1:2], 2'b00};
      ir_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[WIDTH-1:2], 2'b00};
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Control-flow inputs only matter on the completing cycle.
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  next_pc_calc #(.WIDTH(WIDTH)) u_next_pc (
    .pc_plus4_i (pc_plus4),
    .imm_i      (imm),
    .jaddr_i    (jaddr),
    .jump_i     (Jump),
    .branch_i   (Branch),
    .zero_i     (Zero),
    .next_pc_o  (next_pc)
  );

  // The state register already sits in S_FETCH during reset, so the request
  // is additionally gated by rst_n to stay quiet until release.
  assign imem_req    = rst_n && (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + WIDTH'(4);

  assign OP    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign Funct = ir_q[5:0];
  assign imm   = ir_q[15:0];
  assign jaddr = ir_q[25:0];

endmodule
